// File: rtl/gtech_tie_monitor.sv
// ============================================================================
// Module      : gtech_tie_monitor
// Description : Supervises nets driven by generic tie cells. Each net is
//               synchronised, glitch-filtered with a per-bit persistence
//               counter, and a persistent deviation from EXPECT is logged as
//               a sticky fault with a saturating event counter.
//               Optional feature macro: GTECH_TIE_MON_IRQ_EN adds the IRQ
//               port, a one-cycle pulse on entry to the fault state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gtech_tie_monitor #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     EXPECT  = {WIDTH{1'b1}},
    parameter int unsigned          FILT    = 3,
    parameter int unsigned          ARM_CYC = 4,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic                CP,
    input  logic                RST,
    input  logic [WIDTH-1:0]    A,
    input  logic                CLR,
    output logic                ARMED,
    output logic                FAULT,
    output logic [WIDTH-1:0]    FMASK,
    output logic [CNT_W-1:0]    ERR_CNT
`ifdef GTECH_TIE_MON_IRQ_EN
    ,
    output logic                IRQ
`endif
);

    localparam int unsigned c_PC_W = $clog2(FILT + 1);
    localparam int unsigned c_AC_W = $clog2(ARM_CYC + 1);

    localparam logic [c_PC_W-1:0] c_FILT_MAX = c_PC_W'(FILT);
    localparam logic [c_PC_W-1:0] c_FILT_PRE = c_PC_W'(FILT - 1);
    localparam logic [c_AC_W-1:0] c_ARM_LAST = c_AC_W'(ARM_CYC - 1);

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    logic [WIDTH-1:0]   r_sync1_q;
    logic [WIDTH-1:0]   r_sync2_q;
    logic [WIDTH-1:0]   w_dev;
    logic [WIDTH-1:0]   w_conf;

    state_t             r_state_q,   w_state_d;
    logic [c_AC_W-1:0]  r_arm_cnt_q, w_arm_cnt_d;
    logic [c_PC_W-1:0]  r_pc_q [WIDTH];
    logic [c_PC_W-1:0]  w_pc_d [WIDTH];
    logic               r_armed_q,   w_armed_d;
    logic               r_fault_q,   w_fault_d;
    logic [WIDTH-1:0]   r_fmask_q,   w_fmask_d;
    logic [CNT_W-1:0]   r_err_q,     w_err_d;
`ifdef GTECH_TIE_MON_IRQ_EN
    logic               r_irq_q,     w_irq_d;
`endif

    // Two-flop synchroniser; resets to the expected constant so a fresh reset reads clean
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            r_sync1_q <= EXPECT;
            r_sync2_q <= EXPECT;
        end else begin
            r_sync1_q <= A;
            r_sync2_q <= r_sync1_q;
        end
    end

    assign w_dev = r_sync2_q ^ EXPECT;

    // Next-state logic: arming delay, per-bit persistence filter, fault capture and acknowledge
    always_comb begin
        w_state_d   = r_state_q;
        w_arm_cnt_d = r_arm_cnt_q;
        w_pc_d      = r_pc_q;
        w_armed_d   = r_armed_q;
        w_fault_d   = r_fault_q;
        w_fmask_d   = r_fmask_q;
        w_err_d     = r_err_q;
        w_conf      = '0;
`ifdef GTECH_TIE_MON_IRQ_EN
        w_irq_d     = 1'b0;
`endif
        case (r_state_q)
            ST_ARM: begin
                if (r_arm_cnt_q == c_ARM_LAST) begin
                    w_state_d = ST_MONITOR;
                    w_armed_d = 1'b1;
                end else begin
                    w_arm_cnt_d = r_arm_cnt_q + 1'b1;
                end
            end
            ST_MONITOR, ST_FAULT: begin
                // A bit confirms only on the step into saturation, so a held
                // deviation logs once until it drops away again.
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (w_dev[i]) begin
                        if (r_pc_q[i] == c_FILT_PRE) begin
                            w_conf[i] = 1'b1;
                        end
                        if (r_pc_q[i] != c_FILT_MAX) begin
                            w_pc_d[i] = r_pc_q[i] + 1'b1;
                        end
                    end else begin
                        w_pc_d[i] = '0;
                    end
                end
                // The event counter records every confirmation edge, even one
                // that coincides with an acknowledge.
                if ((|w_conf) && (r_err_q != {CNT_W{1'b1}})) begin
                    w_err_d = r_err_q + 1'b1;
                end
                if ((r_state_q == ST_FAULT) && CLR) begin
                    w_state_d = ST_MONITOR;
                    w_fault_d = 1'b0;
                    w_fmask_d = '0;
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        w_pc_d[i] = '0;
                    end
                end else if (|w_conf) begin
                    w_state_d = ST_FAULT;
                    w_fault_d = 1'b1;
                    w_fmask_d = r_fmask_q | w_conf;
`ifdef GTECH_TIE_MON_IRQ_EN
                    w_irq_d   = (r_state_q == ST_MONITOR);
`endif
                end
            end
            default: begin
                w_state_d   = ST_ARM;
                w_arm_cnt_d = '0;
                w_armed_d   = 1'b0;
                w_fault_d   = 1'b0;
                w_fmask_d   = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            r_state_q   <= ST_ARM;
            r_arm_cnt_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_pc_q[i] <= '0;
            end
            r_armed_q   <= 1'b0;
            r_fault_q   <= 1'b0;
            r_fmask_q   <= '0;
            r_err_q     <= '0;
`ifdef GTECH_TIE_MON_IRQ_EN
            r_irq_q     <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_arm_cnt_q <= w_arm_cnt_d;
            r_pc_q      <= w_pc_d;
            r_armed_q   <= w_armed_d;
            r_fault_q   <= w_fault_d;
            r_fmask_q   <= w_fmask_d;
            r_err_q     <= w_err_d;
`ifdef GTECH_TIE_MON_IRQ_EN
            r_irq_q     <= w_irq_d;
`endif
        end
    end

    assign ARMED   = r_armed_q;
    assign FAULT   = r_fault_q;
    assign FMASK   = r_fmask_q;
    assign ERR_CNT = r_err_q;
`ifdef GTECH_TIE_MON_IRQ_EN
    assign IRQ     = r_irq_q;
`endif

endmodule

`default_nettype wire
